// File: rtl/reorder_buffer_pkg.sv
// Shared widths, sizes and entry type codes for the reorder buffer and its
// consumers (decoder, CDB, register file).
package reorder_buffer_pkg;

  localparam int ROB_SIZE    = 16;
  localparam int ROB_POS_WID = $clog2(ROB_SIZE);
  localparam int ROB_ID_WID  = ROB_POS_WID + 1;
  localparam int DATA_WID    = 32;
  localparam int ADDR_WID    = 32;
  localparam int REG_POS_WID = 5;

  typedef enum logic [1:0] {
    TYPE_REG = 2'd0,
    TYPE_BR  = 2'd1,
    TYPE_ST  = 2'd2
  } rob_type_e;

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, CDB, operand-query and commit/rollback signals between the reorder
// buffer (slave) and the surrounding pipeline (master).
interface reorder_buffer_if #(
  parameter int POS_W = reorder_buffer_pkg::ROB_POS_WID
);
  import reorder_buffer_pkg::*;

  logic                   issue;
  rob_type_e              issue_type;
  logic [REG_POS_WID-1:0] issue_rd;
  logic                   issue_pred_jump;
  logic                   issue_ready;
  logic [DATA_WID-1:0]    issue_val;
  logic [ADDR_WID-1:0]    issue_alt_pc;
  logic [POS_W-1:0]       rob_tail;
  logic                   rob_full;

  logic                   cdb_valid;
  logic [POS_W-1:0]       cdb_rob_pos;
  logic [DATA_WID-1:0]    cdb_val;
  logic                   cdb_real_jump;

  logic [POS_W-1:0]       query_pos1;
  logic [POS_W-1:0]       query_pos2;
  logic                   query_ready1;
  logic                   query_ready2;
  logic [DATA_WID-1:0]    query_val1;
  logic [DATA_WID-1:0]    query_val2;

  logic                   rob_commit;
  logic [REG_POS_WID-1:0] rob_commit_rd;
  logic [DATA_WID-1:0]    rob_commit_val;
  logic [POS_W-1:0]       rob_commit_rob_pos;
  logic                   rob_commit_store;
  logic                   rollback;
  logic [ADDR_WID-1:0]    rollback_pc;

  modport slave (
    input  issue, issue_type, issue_rd, issue_pred_jump, issue_ready, issue_val, issue_alt_pc,
    input  cdb_valid, cdb_rob_pos, cdb_val, cdb_real_jump, query_pos1, query_pos2,
    output rob_tail, rob_full, query_ready1, query_ready2, query_val1, query_val2,
    output rob_commit, rob_commit_rd, rob_commit_val, rob_commit_rob_pos, rob_commit_store,
    output rollback, rollback_pc
  );

  modport master (
    output issue, issue_type, issue_rd, issue_pred_jump, issue_ready, issue_val, issue_alt_pc,
    output cdb_valid, cdb_rob_pos, cdb_val, cdb_real_jump, query_pos1, query_pos2,
    input  rob_tail, rob_full, query_ready1, query_ready2, query_val1, query_val2,
    input  rob_commit, rob_commit_rd, rob_commit_val, rob_commit_rob_pos, rob_commit_store,
    input  rollback, rollback_pc
  );

endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at tail, completes from the CDB,
// retires one entry per cycle at head and flushes on a mispredicted branch.
module reorder_buffer #(
  parameter int ROB_SIZE = reorder_buffer_pkg::ROB_SIZE
) (
  input logic              clk,
  input logic              rst,
  input logic              rdy,
  reorder_buffer_if.slave  bus
);
  import reorder_buffer_pkg::*;

  localparam int POS_W = $clog2(ROB_SIZE);
  localparam int CNT_W = POS_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ROB_SIZE);

  logic [ROB_SIZE-1:0]    busy;
  logic [ROB_SIZE-1:0]    ready;
  logic [ROB_SIZE-1:0]    ent_pred;
  logic [ROB_SIZE-1:0]    ent_real;
  rob_type_e              ent_type [ROB_SIZE];
  logic [REG_POS_WID-1:0] ent_rd   [ROB_SIZE];
  logic [DATA_WID-1:0]    ent_val  [ROB_SIZE];
  logic [ADDR_WID-1:0]    ent_alt  [ROB_SIZE];

  logic [POS_W-1:0]       head;
  logic [POS_W-1:0]       tail;
  logic [CNT_W-1:0]       count;

  logic                   commit_q;
  logic                   store_q;
  logic                   rollback_q;
  logic [REG_POS_WID-1:0] commit_rd_q;
  logic [DATA_WID-1:0]    commit_val_q;
  logic [POS_W-1:0]       commit_pos_q;
  logic [ADDR_WID-1:0]    rollback_pc_q;

  logic                   retire;
  logic                   issue_acc;
  logic                   mispredict;

  // A pending rollback pulse suppresses retirement and allocation: everything
  // younger than the branch is about to be discarded.
  always_comb begin
    retire     = busy[head] && ready[head] && !rollback_q;
    issue_acc  = bus.issue && !rollback_q && ((count < CNT_MAX) || retire);
    mispredict = (ent_type[head] == TYPE_BR) && (ent_pred[head] != ent_real[head]);
  end

  // Entry payload: not reset, qualified by busy/ready.
  always_ff @(posedge clk) begin
    if (rdy && !rollback_q) begin
      if (bus.cdb_valid && busy[bus.cdb_rob_pos]) begin
        ent_val[bus.cdb_rob_pos]  <= bus.cdb_val;
        ent_real[bus.cdb_rob_pos] <= bus.cdb_real_jump;
      end
      if (issue_acc) begin
        ent_type[tail] <= bus.issue_type;
        ent_rd[tail]   <= bus.issue_rd;
        ent_val[tail]  <= bus.issue_val;
        ent_alt[tail]  <= bus.issue_alt_pc;
        ent_pred[tail] <= bus.issue_pred_jump;
        ent_real[tail] <= bus.issue_pred_jump;
      end
    end
  end

  // Control and registered commit outputs; issue writes last so allocating
  // into the slot retired this same cycle takes effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy          <= '0;
      ready         <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      commit_q      <= 1'b0;
      store_q       <= 1'b0;
      rollback_q    <= 1'b0;
      commit_rd_q   <= '0;
      commit_val_q  <= '0;
      commit_pos_q  <= '0;
      rollback_pc_q <= '0;
    end else if (rdy) begin
      if (rollback_q) begin
        busy       <= '0;
        ready      <= '0;
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        commit_q   <= 1'b0;
        store_q    <= 1'b0;
        rollback_q <= 1'b0;
      end else begin
        commit_q   <= retire;
        store_q    <= retire && (ent_type[head] == TYPE_ST);
        rollback_q <= retire && mispredict;
        if (bus.cdb_valid && busy[bus.cdb_rob_pos]) begin
          ready[bus.cdb_rob_pos] <= 1'b1;
        end
        if (retire) begin
          busy[head]   <= 1'b0;
          ready[head]  <= 1'b0;
          head         <= head + 1'b1;
          commit_rd_q  <= (ent_type[head] == TYPE_ST) ? '0 : ent_rd[head];
          commit_val_q <= ent_val[head];
          commit_pos_q <= head;
          if (mispredict) begin
            rollback_pc_q <= ent_alt[head];
          end
        end
        if (issue_acc) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= bus.issue_ready;
          tail        <= tail + 1'b1;
        end
        count <= count + CNT_W'(issue_acc) - CNT_W'(retire);
      end
    end
  end

  // Operand lookup with same-cycle CDB bypass.
  always_comb begin
    bus.query_ready1 = busy[bus.query_pos1] && ready[bus.query_pos1];
    bus.query_val1   = ent_val[bus.query_pos1];
    if (bus.cdb_valid && (bus.cdb_rob_pos == bus.query_pos1)) begin
      bus.query_ready1 = 1'b1;
      bus.query_val1   = bus.cdb_val;
    end
    bus.query_ready2 = busy[bus.query_pos2] && ready[bus.query_pos2];
    bus.query_val2   = ent_val[bus.query_pos2];
    if (bus.cdb_valid && (bus.cdb_rob_pos == bus.query_pos2)) begin
      bus.query_ready2 = 1'b1;
      bus.query_val2   = bus.cdb_val;
    end
  end

  assign bus.rob_tail           = tail;
  assign bus.rob_full           = (count >= (CNT_MAX - CNT_W'(1)));
  assign bus.rob_commit         = commit_q && rdy;
  assign bus.rob_commit_store   = store_q && rdy;
  assign bus.rollback           = rollback_q && rdy;
  assign bus.rob_commit_rd      = commit_rd_q;
  assign bus.rob_commit_val     = commit_val_q;
  assign bus.rob_commit_rob_pos = commit_pos_q;
  assign bus.rollback_pc        = rollback_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: in-order commit, full/wrap, rollback,
// stores, operand bypass, rdy freeze and reset override.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   vecs = 0;
  int   errs = 0;

  reorder_buffer_if bus();

  reorder_buffer #(.ROB_SIZE(16)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 100000", $time);
    $fatal(1, "watchdog expired");
  end

  // commit bundle: {commit, store, rd, pos, val} = 1+1+5+4+32 bits
  logic [42:0] cm_exp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.issue           = 1'b0;
    bus.issue_type      = TYPE_REG;
    bus.issue_rd        = '0;
    bus.issue_pred_jump = 1'b0;
    bus.issue_ready     = 1'b0;
    bus.issue_val       = '0;
    bus.issue_alt_pc    = '0;
    bus.cdb_valid       = 1'b0;
    bus.cdb_rob_pos     = '0;
    bus.cdb_val         = '0;
    bus.cdb_real_jump   = 1'b0;
  endtask

  task automatic set_issue(input rob_type_e t, input logic [4:0] rd, input logic rdy_i,
                           input logic [31:0] v, input logic pred, input logic [31:0] alt);
    bus.issue           = 1'b1;
    bus.issue_type      = t;
    bus.issue_rd        = rd;
    bus.issue_ready     = rdy_i;
    bus.issue_val       = v;
    bus.issue_pred_jump = pred;
    bus.issue_alt_pc    = alt;
  endtask

  task automatic set_cdb(input logic [3:0] pos, input logic [31:0] v, input logic rj);
    bus.cdb_valid     = 1'b1;
    bus.cdb_rob_pos   = pos;
    bus.cdb_val       = v;
    bus.cdb_real_jump = rj;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = 1'b1;
    clear_in();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if ({bus.rob_commit, bus.rob_commit_store, bus.rob_commit_rd, bus.rob_commit_rob_pos, bus.rob_commit_val} !== 43'd0) begin
      errs++;
      $display("FAIL reset_commit: got %h want 0", {bus.rob_commit, bus.rob_commit_store, bus.rob_commit_rd, bus.rob_commit_rob_pos, bus.rob_commit_val});
    end
    vecs++;
    if ({bus.rollback, bus.rollback_pc} !== 33'd0) begin
      errs++;
      $display("FAIL reset_rollback: got %h want 0", {bus.rollback, bus.rollback_pc});
    end
    vecs++;
    if ({bus.rob_tail, bus.rob_full} !== 5'd0) begin
      errs++;
      $display("FAIL reset_tail_full: got %h want 0", {bus.rob_tail, bus.rob_full});
    end
  endtask

  task automatic test_basic();
    do_reset();
    set_issue(TYPE_REG, 5'd5, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    clear_in();
    vecs++;
    if (bus.rob_tail !== 4'd1) begin
      errs++;
      $display("FAIL basic_tail: got %0d want 1", bus.rob_tail);
    end
    set_cdb(4'd0, 32'h1234, 1'b0);
    tick();
    clear_in();
    vecs++;
    if (bus.rob_commit !== 1'b0) begin
      errs++;
      $display("FAIL basic_early_commit: got %b want 0", bus.rob_commit);
    end
    tick();
    cm_exp = {1'b1, 1'b0, 5'd5, 4'd0, 32'h1234};
    vecs++;
    if ({bus.rob_commit, bus.rob_commit_store, bus.rob_commit_rd, bus.rob_commit_rob_pos, bus.rob_commit_val} !== cm_exp) begin
      errs++;
      $display("FAIL basic_commit: got %h want %h", {bus.rob_commit, bus.rob_commit_store, bus.rob_commit_rd, bus.rob_commit_rob_pos, bus.rob_commit_val}, cm_exp);
    end
    tick();
    vecs++;
    if (bus.rob_commit !== 1'b0) begin
      errs++;
      $display("FAIL basic_pulse_width: got %b want 0", bus.rob_commit);
    end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_issue(TYPE_REG, 5'(i + 1), 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      vecs++;
      if ({bus.rob_tail, bus.rob_full, bus.rob_commit} !== {4'((i + 1) % 16), (i + 1) >= 15, 1'b0}) begin
        errs++;
        $display("FAIL full_fill[%0d]: got tail=%0d full=%b commit=%b want tail=%0d full=%b commit=0",
                 i, bus.rob_tail, bus.rob_full, bus.rob_commit, (i + 1) % 16, (i + 1) >= 15);
      end
    end
    set_issue(TYPE_REG, 5'd31, 1'b1, 32'hDEAD, 1'b0, 32'h0);
    tick();
    clear_in();
    vecs++;
    if ({bus.rob_tail, bus.rob_full} !== {4'd0, 1'b1}) begin
      errs++;
      $display("FAIL full_drop: got tail=%0d full=%b want tail=0 full=1", bus.rob_tail, bus.rob_full);
    end
    set_cdb(4'd0, 32'hAA, 1'b0);
    tick();
    clear_in();
    tick();
    cm_exp = {1'b1, 1'b0, 5'd1, 4'd0, 32'hAA};
    vecs++;
    if ({bus.rob_commit, bus.rob_commit_store, bus.rob_commit_rd, bus.rob_commit_rob_pos, bus.rob_commit_val} !== cm_exp) begin
      errs++;
      $display("FAIL full_head_commit: got %h want %h", {bus.rob_commit, bus.rob_commit_store, bus.rob_commit_rd, bus.rob_commit_rob_pos, bus.rob_commit_val}, cm_exp);
    end
  endtask

  task automatic test_out_of_order();
    logic [42:0] exp_seq [3];
    exp_seq[0] = {1'b1, 1'b0, 5'd1, 4'd0, 32'h20};
    exp_seq[1] = {1'b1, 1'b0, 5'd2, 4'd1, 32'h21};
    exp_seq[2] = {1'b1, 1'b0, 5'd3, 4'd2, 32'h22};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_issue(TYPE_REG, 5'(i + 1), 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
    end
    clear_in();
    set_cdb(4'd2, 32'h22, 1'b0);
    tick();
    set_cdb(4'd0, 32'h20, 1'b0);
    tick();
    vecs++;
    if (bus.rob_commit !== 1'b0) begin
      errs++;
      $display("FAIL ooo_no_commit: got %b want 0", bus.rob_commit);
    end
    set_cdb(4'd1, 32'h21, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      clear_in();
      vecs++;
      if ({bus.rob_commit, bus.rob_commit_store, bus.rob_commit_rd, bus.rob_commit_rob_pos, bus.rob_commit_val} !== exp_seq[i]) begin
        errs++;
        $display("FAIL ooo_commit[%0d]: got %h want %h", i, {bus.rob_commit, bus.rob_commit_store, bus.rob_commit_rd, bus.rob_commit_rob_pos, bus.rob_commit_val}, exp_seq[i]);
      end
    end
    tick();
    vecs++;
    if (bus.rob_commit !== 1'b0) begin
      errs++;
      $display("FAIL ooo_drain: got %b want 0", bus.rob_commit);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    set_issue(TYPE_BR, 5'd1, 1'b0, 32'h0, 1'b0, 32'h100);
    tick();
    set_issue(TYPE_REG, 5'd2, 1'b1, 32'h55, 1'b0, 32'h0);
    tick();
    set_issue(TYPE_REG, 5'd3, 1'b1, 32'h66, 1'b0, 32'h0);
    tick();
    clear_in();
    set_cdb(4'd0, 32'h4, 1'b1);
    tick();
    clear_in();
    tick();
    cm_exp = {1'b1, 1'b0, 5'd1, 4'd0, 32'h4};
    vecs++;
    if ({bus.rob_commit, bus.rob_commit_store, bus.rob_commit_rd, bus.rob_commit_rob_pos, bus.rob_commit_val} !== cm_exp) begin
      errs++;
      $display("FAIL mis_branch_commit: got %h want %h", {bus.rob_commit, bus.rob_commit_store, bus.rob_commit_rd, bus.rob_commit_rob_pos, bus.rob_commit_val}, cm_exp);
    end
    vecs++;
    if ({bus.rollback, bus.rollback_pc} !== {1'b1, 32'h100}) begin
      errs++;
      $display("FAIL mis_rollback: got %h want %h", {bus.rollback, bus.rollback_pc}, {1'b1, 32'h100});
    end
    // inputs during the rollback pulse must be discarded
    set_issue(TYPE_REG, 5'd9, 1'b1, 32'h99, 1'b0, 32'h0);
    set_cdb(4'd1, 32'hBAD, 1'b0);
    tick();
    clear_in();
    vecs++;
    if ({bus.rob_commit, bus.rollback, bus.rob_tail, bus.rob_full} !== 7'd0) begin
      errs++;
      $display("FAIL mis_flush: got commit=%b rollback=%b tail=%0d full=%b want all 0", bus.rob_commit, bus.rollback, bus.rob_tail, bus.rob_full);
    end
    tick();
    vecs++;
    if ({bus.rob_commit, bus.rob_tail} !== 5'd0) begin
      errs++;
      $display("FAIL mis_no_younger: got commit=%b tail=%0d want commit=0 tail=0", bus.rob_commit, bus.rob_tail);
    end
    set_issue(TYPE_REG, 5'd7, 1'b1, 32'h77, 1'b0, 32'h0);
    tick();
    clear_in();
    tick();
    cm_exp = {1'b1, 1'b0, 5'd7, 4'd0, 32'h77};
    vecs++;
    if ({bus.rob_commit, bus.rob_commit_store, bus.rob_commit_rd, bus.rob_commit_rob_pos, bus.rob_commit_val} !== cm_exp) begin
      errs++;
      $display("FAIL mis_restart: got %h want %h", {bus.rob_commit, bus.rob_commit_store, bus.rob_commit_rd, bus.rob_commit_rob_pos, bus.rob_commit_val}, cm_exp);
    end
  endtask

  task automatic test_branch_ok();
    do_reset();
    set_issue(TYPE_BR, 5'd2, 1'b0, 32'h0, 1'b1, 32'h300);
    tick();
    clear_in();
    set_cdb(4'd0, 32'h8, 1'b1);
    tick();
    clear_in();
    tick();
    cm_exp = {1'b1, 1'b0, 5'd2, 4'd0, 32'h8};
    vecs++;
    if ({bus.rob_commit, bus.rob_commit_store, bus.rob_commit_rd, bus.rob_commit_rob_pos, bus.rob_commit_val} !== cm_exp) begin
      errs++;
      $display("FAIL br_ok_commit: got %h want %h", {bus.rob_commit, bus.rob_commit_store, bus.rob_commit_rd, bus.rob_commit_rob_pos, bus.rob_commit_val}, cm_exp);
    end
    vecs++;
    if (bus.rollback !== 1'b0) begin
      errs++;
      $display("FAIL br_ok_rollback: got %b want 0", bus.rollback);
    end
  endtask

  task automatic test_store();
    do_reset();
    set_issue(TYPE_ST, 5'd9, 1'b1, 32'h5, 1'b0, 32'h0);
    tick();
    clear_in();
    tick();
    vecs++;
    if ({bus.rob_commit, bus.rob_commit_store, bus.rob_commit_rd, bus.rob_commit_rob_pos} !== {1'b1, 1'b1, 5'd0, 4'd0}) begin
      errs++;
      $display("FAIL store_commit: got commit=%b store=%b rd=%0d pos=%0d want 1 1 0 0", bus.rob_commit, bus.rob_commit_store, bus.rob_commit_rd, bus.rob_commit_rob_pos);
    end
    tick();
    vecs++;
    if ({bus.rob_commit, bus.rob_commit_store} !== 2'b00) begin
      errs++;
      $display("FAIL store_pulse: got %b%b want 00", bus.rob_commit, bus.rob_commit_store);
    end
  endtask

  task automatic test_query_and_freeze();
    do_reset();
    set_issue(TYPE_REG, 5'd4, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    set_issue(TYPE_REG, 5'd5, 1'b1, 32'h99, 1'b0, 32'h0);
    tick();
    clear_in();
    bus.query_pos1 = 4'd0;
    bus.query_pos2 = 4'd1;
    set_cdb(4'd0, 32'hABCD, 1'b0);
    #1;
    vecs++;
    if ({bus.query_ready1, bus.query_val1} !== {1'b1, 32'hABCD}) begin
      errs++;
      $display("FAIL query_bypass: got %h want %h", {bus.query_ready1, bus.query_val1}, {1'b1, 32'hABCD});
    end
    vecs++;
    if ({bus.query_ready2, bus.query_val2} !== {1'b1, 32'h99}) begin
      errs++;
      $display("FAIL query_stored: got %h want %h", {bus.query_ready2, bus.query_val2}, {1'b1, 32'h99});
    end
    bus.cdb_valid = 1'b0;
    #1;
    vecs++;
    if (bus.query_ready1 !== 1'b0) begin
      errs++;
      $display("FAIL query_not_ready: got %b want 0", bus.query_ready1);
    end
    rdy = 1'b0;
    set_issue(TYPE_REG, 5'd6, 1'b1, 32'h66, 1'b0, 32'h0);
    set_cdb(4'd0, 32'hABCD, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if ({bus.rob_commit, bus.rob_tail} !== {1'b0, 4'd2}) begin
        errs++;
        $display("FAIL freeze[%0d]: got commit=%b tail=%0d want commit=0 tail=2", i, bus.rob_commit, bus.rob_tail);
      end
    end
    rdy = 1'b1;
    clear_in();
    #1;
    vecs++;
    if ({bus.query_ready1, bus.rob_tail} !== {1'b0, 4'd2}) begin
      errs++;
      $display("FAIL freeze_held: got ready1=%b tail=%0d want ready1=0 tail=2", bus.query_ready1, bus.rob_tail);
    end
    set_cdb(4'd0, 32'hABCD, 1'b0);
    tick();
    clear_in();
    tick();
    cm_exp = {1'b1, 1'b0, 5'd4, 4'd0, 32'hABCD};
    vecs++;
    if ({bus.rob_commit, bus.rob_commit_store, bus.rob_commit_rd, bus.rob_commit_rob_pos, bus.rob_commit_val} !== cm_exp) begin
      errs++;
      $display("FAIL resume_commit0: got %h want %h", {bus.rob_commit, bus.rob_commit_store, bus.rob_commit_rd, bus.rob_commit_rob_pos, bus.rob_commit_val}, cm_exp);
    end
    tick();
    cm_exp = {1'b1, 1'b0, 5'd5, 4'd1, 32'h99};
    vecs++;
    if ({bus.rob_commit, bus.rob_commit_store, bus.rob_commit_rd, bus.rob_commit_rob_pos, bus.rob_commit_val} !== cm_exp) begin
      errs++;
      $display("FAIL resume_commit1: got %h want %h", {bus.rob_commit, bus.rob_commit_store, bus.rob_commit_rd, bus.rob_commit_rob_pos, bus.rob_commit_val}, cm_exp);
    end
  endtask

  task automatic test_reset_over_rollback();
    do_reset();
    set_issue(TYPE_BR, 5'd3, 1'b0, 32'h0, 1'b0, 32'h200);
    tick();
    clear_in();
    set_cdb(4'd0, 32'h0, 1'b1);
    tick();
    clear_in();
    tick();
    vecs++;
    if ({bus.rollback, bus.rollback_pc} !== {1'b1, 32'h200}) begin
      errs++;
      $display("FAIL rst_pre_rollback: got %h want %h", {bus.rollback, bus.rollback_pc}, {1'b1, 32'h200});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++;
    if ({bus.rollback, bus.rollback_pc, bus.rob_commit, bus.rob_tail} !== 38'd0) begin
      errs++;
      $display("FAIL rst_override: got rollback=%b pc=%h commit=%b tail=%0d want all 0", bus.rollback, bus.rollback_pc, bus.rob_commit, bus.rob_tail);
    end
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    bus.query_pos1 = '0;
    bus.query_pos2 = '0;
    clear_in();
    test_reset();
    test_basic();
    test_full_wrap();
    test_out_of_order();
    test_mispredict();
    test_branch_ok();
    test_store();
    test_query_and_freeze();
    test_reset_over_rollback();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular in-order reorder buffer between the decoder/issue stage, the execution units and the register file. Allocates one entry per issued instruction, collects results from the CDB, retires the head entry in program order, and drives the commit/rollback interface the register file consumes. Detects branch mispredictions at retirement and flushes the machine.

## Interface
Parameters:
- ROB_SIZE, 16: entry count, power of two; pointer width = log2(ROB_SIZE) (`ROB_POS_WID`)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; low freezes all state and forces pulse outputs low
- issue  in  1  allocate an entry this cycle
- issue_type  in  2  0=reg-write, 1=branch, 2=store
- issue_rd  in  `REG_POS_WID`  destination register
- issue_pred_jump  in  1  predicted taken
- issue_ready  in  1  entry complete at issue (stores, LUI)
- issue_val  in  `DATA_WID`  value when issue_ready
- issue_alt_pc  in  `ADDR_WID`  correct PC if prediction is wrong
- rob_tail  out  `ROB_POS_WID`  position the next issue receives
- rob_full  out  1  no issue accepted next cycle
- cdb_valid  in  1  result broadcast
- cdb_rob_pos  in  `ROB_POS_WID`  target entry
- cdb_val  in  `DATA_WID`  result value
- cdb_real_jump  in  1  actual branch outcome
- query_pos1 / query_pos2  in  `ROB_POS_WID`  decoder operand lookups
- query_ready1 / query_ready2  out  1  entry holds a result (combinational)
- query_val1 / query_val2  out  `DATA_WID`  that result
- rob_commit  out  1  retirement pulse
- rob_commit_rd  out  `REG_POS_WID`
- rob_commit_val  out  `DATA_WID`
- rob_commit_rob_pos  out  `ROB_POS_WID`
- rob_commit_store  out  1  head store may write memory
- rollback  out  1  flush pulse
- rollback_pc  out  `ADDR_WID`  fetch redirect target

## Operation
- Per entry: busy, ready, type, rd, val, pred_jump, real_jump, alt_pc. Pointers head, tail; counter count (0..ROB_SIZE).
- Issue (issue && count<ROB_SIZE): entry[tail] ← fields, busy=1, ready=issue_ready; tail+1 mod ROB_SIZE. Issue when count==ROB_SIZE is dropped.
- CDB write: entry[cdb_rob_pos].val←cdb_val, real_jump←cdb_real_jump, ready=1; ignored if entry not busy.
- Retire: if entry[head] busy&&ready, one per cycle:
  - reg-write: rob_commit=1, rd/val/pos from entry (rd=0 still pulses; register file ignores).
  - store: rob_commit=1 with rd=0, rob_commit_store=1.
  - branch: rob_commit=1 with rd/val (link value). If real_jump≠pred_jump additionally rollback=1, rollback_pc=alt_pc.
  - head+1, busy cleared.
- Rollback: in the cycle after the rollback pulse is produced, head=tail=count=0, all busy/ready cleared; issue and CDB inputs during the rollback-pulse cycle are discarded.
- Query: query_ready = busy&&ready of the addressed entry, or cdb_valid&&cdb_rob_pos matches (bypass, val=cdb_val).
- count update: +issue_accepted −retired, simultaneous both = unchanged.

## Timing
- Reset values: rob_commit, rob_commit_store, rollback 0; rob_commit_rd/val/rob_pos, rollback_pc 0; rob_tail 0; rob_full 0; head=tail=count=0.
- Commit outputs registered: entry ready at edge N → rob_commit high during cycle N+1 (one cycle). CDB write to head at edge N → commit pulse after edge N+1.
- rob_full = count ≥ ROB_SIZE−1 (one-slot margin for the registered decoder).
- Pointer wrap: ROB_SIZE−1 → 0; full with head==tail distinguished by count.
- Issue into slot freed by same-cycle retirement is legal.
- rst mid-flight overrides everything, including a pending rollback.

## Structure
- Constants in cons.v: ROB_SIZE, ROB_POS_WID, ROB_ID_WID, DATA_WID, ADDR_WID, REG_POS_WID, type codes TYPE_REG/TYPE_BR/TYPE_ST.
- Single module; entry arrays as reg vectors; no sub-module needed.

## Test plan
- Reset then issue rd=5, CDB val=0x1234 → one cycle later rob_commit=1, rd=5, val=0x1234, pos=0.
- Issue 16 entries without CDB → rob_full from count=15, 17th issue dropped, rob_tail wraps to 0.
- Results arrive out of order (pos 2 then 0 then 1) → commits emitted in order 0,1,2 on consecutive cycles.
- Branch pred_jump=0, real_jump=1, alt_pc=0x100 with two younger entries → rollback=1, rollback_pc=0x100, next cycle count=0, younger entries never commit.
- Store issued with issue_ready=1 at head → rob_commit_store=1, rob_commit_rd=0.
- Query pos matching same-cycle CDB → query_ready=1, query_val=cdb_val; rdy=0 for 3 cycles → no commit, state held.
